// File: rtl/pb_debounce.sv
// Push-button conditioner: per-bit two-flop synchroniser, stable-time debounce,
// press/release pulses, sticky press events with mask clear, and a level interrupt.
module pb_debounce #(
    parameter int unsigned DB_CYCLES = 1000,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned N_PB      = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_PB-1:0] pb,
    input  logic [N_PB-1:0] ev_clr,
    output logic [N_PB-1:0] pb_level,
    output logic [N_PB-1:0] pb_press,
    output logic [N_PB-1:0] pb_release,
    output logic [N_PB-1:0] pb_event,
    output logic            irq
);

    // Counter value on which a persistent mismatch is accepted as the new level.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

    logic [N_PB-1:0]  s1_q;
    logic [N_PB-1:0]  s2_q;
    logic [N_PB-1:0]  level_q,   level_d;
    logic [N_PB-1:0]  press_q,   press_d;
    logic [N_PB-1:0]  release_q, release_d;
    logic [N_PB-1:0]  event_q,   event_d;
    logic             irq_q,     irq_d;
    logic [CNT_W-1:0] cnt_q [N_PB];
    logic [CNT_W-1:0] cnt_d [N_PB];

    // Per-bit debounce: count consecutive mismatches, flip the level after DB_CYCLES of them.
    always_comb begin
        for (int unsigned i = 0; i < N_PB; i++) begin
            level_d[i]   = level_q[i];
            cnt_d[i]     = cnt_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                level_d[i]   = s2_q[i];
                cnt_d[i]     = '0;
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // A press landing on the same edge as a clear keeps the event set.
        event_d = press_d | (event_q & ~ev_clr);
        irq_d   = |event_d;
    end

    // All state, including the synchroniser, clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            event_q   <= '0;
            irq_q     <= 1'b0;
            for (int unsigned i = 0; i < N_PB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= pb;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            event_q   <= event_d;
            irq_q     <= irq_d;
            for (int unsigned i = 0; i < N_PB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pb_level   = level_q;
    assign pb_press   = press_q;
    assign pb_release = release_q;
    assign pb_event   = event_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce: a window-based reference model predicts every
// post-edge output, a monitor pops and compares one prediction per rising edge.
module tb_pb_debounce;

    localparam int unsigned DB = 4;
    localparam int unsigned N  = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] pb = '0;
    logic [N-1:0] ev_clr = '0;
    logic [N-1:0] pb_level, pb_press, pb_release, pb_event;
    logic         irq;

    pb_debounce #(
        .DB_CYCLES(DB),
        .CNT_W    (3),
        .N_PB     (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb        (pb),
        .ev_clr    (ev_clr),
        .pb_level  (pb_level),
        .pb_press  (pb_press),
        .pb_release(pb_release),
        .pb_event  (pb_event),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] evt;
        logic         irq;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;

    // Reference model: raw samples seen at each edge since reset, plus level and events.
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_evt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        for (int k = 0; k < int'(DB) + 2; k++) m_hist.push_back('0);
        m_lvl = '0;
        m_evt = '0;
    endtask

    // The value acted on at edge e is the pin sampled at edge e-2; the level flips at e
    // when the DB most recent such values all differ from the current level.
    task automatic model_edge(input logic [N-1:0] p, input logic [N-1:0] clr, output exp_t e);
        logic [N-1:0] flip;
        logic [N-1:0] smp;
        m_hist.push_back(p);
        while (m_hist.size() > int'(DB) + 2) void'(m_hist.pop_front());
        flip = '1;
        for (int k = 0; k < int'(DB); k++) begin
            smp = m_hist[k];
            for (int b = 0; b < int'(N); b++) begin
                if (smp[b] == m_lvl[b]) flip[b] = 1'b0;
            end
        end
        e.press = flip & ~m_lvl;
        e.rel   = flip & m_lvl;
        m_lvl   = m_lvl ^ flip;
        m_evt   = e.press | (m_evt & ~clr);
        e.level = m_lvl;
        e.evt   = m_evt;
        e.irq   = |m_evt;
    endtask

    // Drive inputs for the coming rising edge, predict its result, wait for the falling edge.
    task automatic step(input logic [N-1:0] p, input logic [N-1:0] clr, input logic rst);
        exp_t e;
        pb     = p;
        ev_clr = clr;
        rst_n  = rst;
        if (!rst) begin
            model_reset();
            e = '0;
        end else begin
            model_edge(p, clr, e);
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic [N-1:0] p, input logic [N-1:0] clr, input int n);
        for (int k = 0; k < n; k++) step(p, clr, 1'b1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("async reset clears outputs", {pb_level, pb_press, pb_release, pb_event, irq}, '0);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: one prediction per rising edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard underrun at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("pb_level", pb_level, e.level);
                chk("pb_press", pb_press, e.press);
                chk("pb_release", pb_release, e.rel);
                chk("pb_event", pb_event, e.evt);
                chk("irq", irq, e.irq);
            end
        end
    end

    initial begin
        int           hold[N];
        logic [N-1:0] cur;
        logic [N-1:0] clr;

        // 1: reset with all buttons held, then fresh detection after release of reset
        model_reset();
        for (int k = 0; k < 15; k++) step(5'h1f, 5'h00, 1'b0);
        chk("t1 outputs in reset", {pb_level, pb_press, pb_release, pb_event, irq}, '0);
        run(5'h1f, 5'h00, 5);
        chk("t1 level before latency", pb_level, 5'h00);
        step(5'h1f, 5'h00, 1'b1);
        chk("t1 press after edge 5", pb_press, 5'h1f);
        chk("t1 irq after edge 5", irq, 1'b1);
        step(5'h1f, 5'h00, 1'b1);
        chk("t1 press one cycle", pb_press, 5'h00);
        run(5'h00, 5'h1f, 8);
        run(5'h00, 5'h00, 2);

        // 2: single press and release on bit 0
        run(5'h01, 5'h00, 5);
        step(5'h01, 5'h00, 1'b1);
        chk("t2 press bit0", pb_press, 5'h01);
        run(5'h01, 5'h00, 14);
        run(5'h00, 5'h00, 5);
        step(5'h00, 5'h00, 1'b1);
        chk("t2 release bit0", pb_release, 5'h01);
        chk("t2 level after release", pb_level, 5'h00);
        chk("t2 event sticky", pb_event, 5'h01);
        run(5'h00, 5'h1f, 2);
        run(5'h00, 5'h00, 1);

        // 3: bounce on bit 2, then a clean rise
        for (int k = 0; k < 2; k++) begin
            run(5'h04, 5'h00, 2);
            run(5'h00, 5'h00, 2);
        end
        run(5'h04, 5'h00, 5);
        chk("t3 bounce rejected", pb_level, 5'h00);
        step(5'h04, 5'h00, 1'b1);
        chk("t3 press after final rise", pb_press, 5'h04);
        run(5'h04, 5'h00, 3);
        run(5'h00, 5'h1f, 8);
        run(5'h00, 5'h00, 1);

        // 4: clear colliding with press, then clear on the following cycle
        run(5'h02, 5'h00, 5);
        step(5'h02, 5'h02, 1'b1);
        chk("t4 press wins over clear", pb_event, 5'h02);
        step(5'h02, 5'h02, 1'b1);
        chk("t4 event cleared", pb_event, 5'h00);
        chk("t4 irq cleared", irq, 1'b0);
        run(5'h00, 5'h00, 8);

        // 5: independent channels 3 and 4
        run(5'h08, 5'h00, 2);
        run(5'h18, 5'h00, 3);
        step(5'h18, 5'h00, 1'b1);
        chk("t5 press bit3", pb_press, 5'h08);
        step(5'h18, 5'h00, 1'b1);
        step(5'h18, 5'h00, 1'b1);
        chk("t5 press bit4", pb_press, 5'h10);
        step(5'h18, 5'h08, 1'b1);
        chk("t5 irq held by bit4", irq, 1'b1);
        step(5'h18, 5'h10, 1'b1);
        chk("t5 irq after both cleared", irq, 1'b0);
        run(5'h00, 5'h00, 8);

        // 6: reset in the middle of a count
        run(5'h01, 5'h00, 4);
        pulse_reset();
        run(5'h01, 5'h00, 5);
        chk("t6 no press before latency", pb_level, 5'h00);
        step(5'h01, 5'h00, 1'b1);
        chk("t6 press after reset", pb_press, 5'h01);
        run(5'h01, 5'h00, 3);
        run(5'h00, 5'h1f, 8);

        // Random bouncing with glitch lengths straddling the debounce time
        cur = '0;
        for (int b = 0; b < int'(N); b++) hold[b] = $urandom_range(0, 6);
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < int'(N); b++) begin
                if (hold[b] == 0) begin
                    cur[b]  = ~cur[b];
                    hold[b] = $urandom_range(0, 6);
                end else begin
                    hold[b]--;
                end
            end
            clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 199) == 0) pulse_reset();
            step(cur, clr, 1'b1);
        end

        chk("scoreboard drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
